// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
// Operation encodings match the RV32M funct3 field.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } muldiv_state_t;

    // Negation is done at a fixed width wide enough for a 2*XLEN product with XLEN up to 64.
    localparam int unsigned NegW = 130;

    function automatic int unsigned cnt_width(input int unsigned xlen);
        return (xlen < 2) ? 1 : $clog2(xlen);
    endfunction

    // Two's-complement negate when en is set; the low bits are valid for any narrower width.
    function automatic logic [NegW-1:0] cond_negate(input logic [NegW-1:0] x, input logic en);
        return en ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle, shift-add multiply and restoring divide
// on operand magnitudes, with a final sign correction and fast-pathed special divides.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter bit          FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  muldiv_op_t      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int unsigned     CntW   = cnt_width(XLEN);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t     state_q, state_d;
    muldiv_op_t        op_q, op_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [2*XLEN-1:0] acc_q, acc_d;

    logic            accept, a_sgn, b_sgn, a_signed, b_signed, b_zero, ovf, special, neg_in;
    logic [XLEN-1:0] ua, ub, special_res;
    logic [NegW-1:0] a_ext, b_ext, nega_w, negb_w;

    always_comb begin
        accept   = (state_q == StIdle) && in_valid && !flush;
        a_sgn    = a[XLEN-1];
        b_sgn    = b[XLEN-1];
        a_signed = op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
        b_signed = op inside {OpMulh, OpDiv, OpRem};
        b_zero   = (b == '0);
        ovf      = (op == OpDiv || op == OpRem) && (a == MinNeg) && (b == '1);
        special  = FAST_SPECIAL && op[2] && (b_zero || ovf);

        a_ext              = '0;
        a_ext[XLEN-1:0]    = a;
        b_ext              = '0;
        b_ext[XLEN-1:0]    = b;
        nega_w             = cond_negate(a_ext, 1'b1);
        negb_w             = cond_negate(b_ext, 1'b1);
        ua = (a_signed && a_sgn) ? nega_w[XLEN-1:0] : a;
        ub = (b_signed && b_sgn) ? negb_w[XLEN-1:0] : b;

        // Quotient sign is left alone on divide-by-zero so the all-ones result survives.
        case (op)
            OpMulh:   neg_in = a_sgn ^ b_sgn;
            OpMulhsu: neg_in = a_sgn;
            OpDiv:    neg_in = (a_sgn ^ b_sgn) && !b_zero;
            OpRem:    neg_in = a_sgn;
            default:  neg_in = 1'b0;
        endcase

        if (b_zero) begin
            special_res = (op == OpDiv || op == OpDivu) ? '1 : a;
        end else begin
            special_res = (op == OpDiv) ? a : '0;
        end
    end

    logic [XLEN:0]     msum, sh, diff;
    logic [XLEN-1:0]   acc_hi, acc_lo, fin;
    logic [2*XLEN-1:0] mul_next, div_next, iter_next;
    logic [NegW-1:0]   mul_ext, div_ext, fin_mul_w, fin_div_w;

    always_comb begin
        acc_hi   = acc_q[2*XLEN-1:XLEN];
        acc_lo   = acc_q[XLEN-1:0];
        msum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand_q} : '0);
        mul_next = {msum, acc_lo[XLEN-1:1]};

        // Restoring step: high half is the partial remainder, low half shifts in quotient bits.
        sh       = {acc_hi, acc_lo[XLEN-1]};
        diff     = sh - {1'b0, mcand_q};
        div_next = diff[XLEN] ? {sh[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
        iter_next = op_q[2] ? div_next : mul_next;

        mul_ext                = '0;
        mul_ext[2*XLEN-1:0]    = iter_next;
        fin_mul_w              = cond_negate(mul_ext, neg_q);
        div_ext                = '0;
        div_ext[XLEN-1:0]      = (op_q == OpDiv || op_q == OpDivu) ? iter_next[XLEN-1:0]
                                                                   : iter_next[2*XLEN-1:XLEN];
        fin_div_w              = cond_negate(div_ext, neg_q);

        case (op_q)
            OpMul:                     fin = fin_mul_w[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: fin = fin_mul_w[2*XLEN-1:XLEN];
            default:                   fin = fin_div_w[XLEN-1:0];
        endcase
    end

    logic unused_neg;
    assign unused_neg = ^{nega_w[NegW-1:XLEN], negb_w[NegW-1:XLEN],
                          fin_mul_w[NegW-1:2*XLEN], fin_div_w[NegW-1:XLEN]};

    always_comb begin
        op_d    = op_q;
        neg_d   = neg_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        if (accept) begin
            op_d    = op;
            neg_d   = neg_in;
            mcand_d = ub;
            acc_d   = {{XLEN{1'b0}}, ua};
            cnt_d   = CntW'(XLEN - 1);
            res_d   = special_res;
        end else if (state_q == StCalc && !flush) begin
            acc_d = iter_next;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                res_d = fin;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (in_valid) state_d = special ? StDone : StCalc;
                StCalc:  if (cnt_q == '0) state_d = StDone;
                StDone:  if (out_ready) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        result    = out_valid ? res_q : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OpMul;
            neg_q   <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            op_q    <= op_d;
            neg_q   <= neg_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random ops against an arithmetic model,
// and hand-written backpressure, flush and asynchronous-reset sequences.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst, in_valid, flush, out_ready, in_ready, out_valid;
    muldiv_op_t      op;
    logic [XLEN-1:0] a, b, result;

    int checks   = 0;
    int failures = 0;
    logic [XLEN-1:0] exp_q[$];

    typedef struct {
        muldiv_op_t      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        int              lat;
        string           nm;
    } vec_t;

    always #5 clk = ~clk;

    muldiv_unit #(
        .XLEN        (XLEN),
        .FAST_SPECIAL(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result)
    );

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, want);
        end
    endtask

    function automatic logic [XLEN-1:0] model(input muldiv_op_t o, input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
        logic [63:0] p;
        longint      sx, sy, uy;
        int          ix, iy;
        logic        ov;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        uy = longint'({32'b0, y});
        ix = $signed(x);
        iy = $signed(y);
        ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            OpMul:    begin p = {32'b0, x} * {32'b0, y}; return p[31:0];  end
            OpMulh:   begin p = sx * sy;                 return p[63:32]; end
            OpMulhsu: begin p = sx * uy;                 return p[63:32]; end
            OpMulhu:  begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            OpDiv:    return (y == 0) ? '1 : ov ? x : 32'(ix / iy);
            OpDivu:   return (y == 0) ? '1 : x / y;
            OpRem:    return (y == 0) ? x : ov ? '0 : 32'(ix % iy);
            default:  return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Issue one op, measure latency, optionally stall the consumer, then take the result.
    task automatic run_op(input muldiv_op_t o, input logic [XLEN-1:0] ia, input logic [XLEN-1:0] ib,
                          input logic [XLEN-1:0] want, input int exp_lat, input int hold,
                          input string nm);
        int              lat;
        logic [XLEN-1:0] got;
        @(negedge clk);
        check({nm, " in_ready before issue"}, in_ready, 1);
        check({nm, " out_valid before issue"}, out_valid, 0);
        out_ready = 1'b0;
        op        = o;
        a         = ia;
        b         = ib;
        in_valid  = 1'b1;
        @(posedge clk);
        exp_q.push_back(want);
        @(negedge clk);
        // Operands are scrambled after acceptance; the unit must not see them.
        in_valid = 1'b0;
        op       = OpDivu;
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        while (!out_valid && lat <= 2 * XLEN + 8) begin
            @(negedge clk);
            lat++;
        end
        check({nm, " latency"}, lat, exp_lat);
        if (!out_valid) begin
            void'(exp_q.pop_back());
            return;
        end
        got = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({nm, " held result"}, result, got);
            check({nm, " in_ready while done"}, in_ready, 0);
            check({nm, " out_valid while stalled"}, out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        check({nm, " scoreboard depth"}, exp_q.size(), 1);
        if (exp_q.size() != 0) check({nm, " result"}, got, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t            vecs[$];
        muldiv_op_t      ro;
        logic [XLEN-1:0] rx, ry;
        int              seen;

        vecs.push_back('{OpMul,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul 7*-3"});
        vecs.push_back('{OpMulh,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, "mulh min*min"});
        vecs.push_back('{OpMulhu,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu max*max"});
        vecs.push_back('{OpMulhsu, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33, "mulhsu -1*2"});
        vecs.push_back('{OpMulh,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33, "mulh -1*-1"});
        vecs.push_back('{OpDiv,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, "div -7/2"});
        vecs.push_back('{OpRem,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, "rem -7%2"});
        vecs.push_back('{OpDiv,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div 7/-2"});
        vecs.push_back('{OpRem,    32'd7,          32'hFFFF_FFFE, 32'd1,         33, "rem 7%-2"});
        vecs.push_back('{OpDivu,   32'd100,        32'd7,         32'd14,        33, "divu 100/7"});
        vecs.push_back('{OpRemu,   32'd100,        32'd7,         32'd2,         33, "remu 100%7"});
        vecs.push_back('{OpDivu,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33, "divu max/1"});
        vecs.push_back('{OpDiv,    32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "div 5/0"});
        vecs.push_back('{OpRemu,   32'd5,          32'd0,         32'd5,         1,  "remu 5%0"});
        vecs.push_back('{OpDivu,   32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "divu 5/0"});
        vecs.push_back('{OpRem,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1,  "rem -5%0"});
        vecs.push_back('{OpDiv,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  "div min/-1"});
        vecs.push_back('{OpRem,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  "rem min%-1"});

        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        op        = OpMul;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0, vecs[i].nm);
        end

        for (int i = 0; i < 8; i++) begin
            ro = muldiv_op_t'($urandom_range(0, 7));
            rx = $urandom;
            ry = (i == 7) ? 32'd0 : $urandom;
            run_op(ro, rx, ry, model(ro, rx, ry), (ro[2] && ry == 0) ? 1 : 33, 0, "random op");
        end

        // Backpressure, then back-to-back acceptance in the following cycle.
        run_op(OpMul, 32'd1234, 32'd5678, 32'd7006652, 33, 10, "backpressure mul");
        run_op(OpDivu, 32'd1000, 32'd10, 32'd100, 33, 0, "after backpressure");

        // Flush in the fifth CALC cycle.
        @(negedge clk);
        out_ready = 1'b0;
        op        = OpDivu;
        a         = 32'd1000;
        b         = 32'd3;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush in_ready", in_ready, 1);
        check("flush out_valid", out_valid, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("flush no late out_valid", seen, 0);
        run_op(OpRemu, 32'd1000, 32'd3, 32'd1, 33, 0, "after flush");

        // Flush together with a request in idle must not accept it.
        @(negedge clk);
        out_ready = 1'b0;
        op        = OpMul;
        a         = 32'd3;
        b         = 32'd3;
        in_valid  = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush+in_valid not accepted", in_ready, 1);

        // Asynchronous reset in the middle of an iteration.
        op       = OpMul;
        a        = 32'd5;
        b        = 32'd6;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("calc in_ready low", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        check("async reset in_ready", in_ready, 1);
        check("async reset out_valid", out_valid, 0);
        check("async reset result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        run_op(OpMulhu, 32'hFFFF_FFFF, 32'd16, 32'hF, 33, 0, "after reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative, parametrised multiply/divide unit implementing the RV32M operation set. It processes one bit per clock with a valid/ready handshake on input and output, and sits beside alu32 in the execute stage. The pipeline stalls on in_ready/out_valid. XLEN is generalised, and divide-by-zero and signed-overflow results are fast-pathed.

Parameters:
XLEN, 32, operand/result width; must be even and >= 8
FAST_SPECIAL, 1, when 1 div-by-zero and signed-overflow cases skip iteration and complete in 1 cycle

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  unit can accept; high only in IDLE
op  input  3  muldiv_op_t: MUL=000 MULH=001 MULHSU=010 MULHU=011 DIV=100 DIVU=101 REM=110 REMU=111
a  input  XLEN  operand rs1
b  input  XLEN  operand rs2
flush  input  1  abort in-flight operation, discard result
out_valid  output  1  result available
out_ready  input  1  consumer takes result
result  output  XLEN  operation result

Behaviour:
- Reset (async, any state) -> IDLE. in_ready=1, out_valid=0, result=0; counter and internal registers cleared.
- States are IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch op, |a|, |b| and result-sign flags, and set cnt=XLEN-1.
  - Divide ops with b==0, or signed DIV/REM with a==most-negative && b==-1, go to DONE directly when FAST_SPECIAL=1.
  - All other accepted ops go to CALC.
- CALC: one iteration per cycle, XLEN cycles total.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - When cnt==0, apply sign correction and go to DONE; otherwise cnt decrements.
- DONE: out_valid=1 and result is held stable until out_ready. On out_valid&&out_ready go to IDLE. The next op can be accepted in the following cycle; there is no same-cycle re-accept.
- Latency from acceptance edge to out_valid high:
  - XLEN+1 cycles for iterated ops.
  - 1 cycle for fast-pathed ops.
  - With FAST_SPECIAL=0, special cases iterate but produce the same values.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU: both operands unsigned.
  - DIV/REM: signed. The quotient is negated when the operand signs differ. The remainder takes the dividend's sign.
- Result selection: MUL returns product[XLEN-1:0]; MULH, MULHSU and MULHU return product[2*XLEN-1:XLEN].
- Special values:
  - Divide-by-zero: DIV/DIVU return all ones; REM/REMU return a.
  - Signed overflow (most-negative / -1): DIV returns a; REM returns 0.
- flush is highest priority after rst. In any state it goes to IDLE next cycle with out_valid=0. A flush coinciding with an out_valid&&out_ready transfer still counts as a completed transfer. A flush coinciding with in_valid in IDLE: the op is not accepted.
- in_valid while busy is ignored; the producer must hold it, as in_ready=0.
- op, a and b are sampled only at acceptance; later changes have no effect.

Decomposition:
- muldiv_pkg holds:
  - muldiv_op_t (3-bit enum, encodings equal RV32M funct3);
  - muldiv_state_t (IDLE/CALC/DONE);
  - localparam widths for the counter, $clog2(XLEN).
- No sub-module. The datapath (abs/negate, shift-add, restore-subtract) is small enough to stay in one file; a shared negate function lives in muldiv_pkg.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB; out_valid exactly 33 cycles after acceptance.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1, b=2 -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD; REM a=-7, b=2 -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU same operands -> 2.
- Special cases, each with out_valid 1 cycle after acceptance:
  - DIV a=5, b=0 -> 0xFFFFFFFF.
  - REMU a=5, b=0 -> 5.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result stable and in_ready=0; then out_ready=1 -> IDLE and the next op is accepted the following cycle.
- Abort cases:
  - flush at CALC cycle 5 -> IDLE next cycle with no out_valid; the next op computes correctly.
  - rst asserted mid-CALC -> outputs reset immediately (asynchronous), without waiting for a clock edge.
